hazard_scoreboard_ctrl: RTL and testbench

Issue controller between fetch and decode/operand-fetch in the 3-stage pipeline. It keeps a 16-entry busy scoreboard of registers awaiting writeback and detects RAW/WAW hazards on the instruction presented by fetch. It stalls fetch or issues the instruction into decode, inserting a bubble on stall. It also caps in-flight writes and flags a stall deadlock.

---
 rtl/hazard_scoreboard_ctrl_if.sv | 41 ++++
 rtl/hazard_scoreboard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_ctrl_if
//   Bundles the fetch, writeback, issue and scoreboard-status signals of the
//   hazard scoreboard issue controller.
//
//   master : the environment side (fetch/execute drive, observes outputs)
//   slave  : the controller side
//
//   instr_valid  fetch presents a valid instruction
//   instr[15:0]  instruction from fetch, opcode in [15:12]
//   wb_valid     execute writes back a register this cycle
//   wb_reg[3:0]  writeback destination register
//   fetch_stall  combinational; fetch must hold instr
//   issue_valid  registered; issue_instr is valid for decode
//   issue_instr  registered instruction to decode (0 when bubble)
//   busy[15:0]   registered scoreboard, bit i = register i pending
//   inflight     registered popcount of busy
//   deadlock_err registered sticky stall-deadlock flag
// ---------------------------------------------------------------------------
interface hazard_scoreboard_ctrl_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic        fetch_stall;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic [15:0] busy;
    logic [4:0]  inflight;
    logic        deadlock_err;

    modport master (
        output instr_valid, instr, wb_valid, wb_reg,
        input  fetch_stall, issue_valid, issue_instr, busy, inflight, deadlock_err
    );

    modport slave (
        input  instr_valid, instr, wb_valid, wb_reg,
        output fetch_stall, issue_valid, issue_instr, busy, inflight, deadlock_err
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_ctrl
//   Issue controller between fetch and decode. Tracks registers awaiting
//   writeback in a 16-entry busy scoreboard, stalls fetch on RAW/WAW hazards
//   or when the in-flight write cap is reached, issues accepted instructions
//   one cycle later (bubble otherwise) and latches a sticky deadlock error
//   after STALL_LIMIT consecutive stall cycles.
//
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : hazard_scoreboard_ctrl_if.slave (fetch, writeback, issue, status)
//
//   MAX_INFLIGHT : max registers simultaneously busy (1..16)
//   STALL_LIMIT  : consecutive stall cycles before deadlock_err (>=1)
//   WB_BYPASS    : 1 = same-cycle writeback resolves a RAW hazard
// ---------------------------------------------------------------------------
module hazard_scoreboard_ctrl #(
    parameter int MAX_INFLIGHT = 2,
    parameter int STALL_LIMIT  = 64,
    parameter int WB_BYPASS    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_scoreboard_ctrl_if.slave  bus
);

    localparam logic [3:0] OP_LOAD  = 4'hE;
    localparam logic [3:0] OP_STORE = 4'hF;
    localparam int         CNT_W    = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_ERR} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   stall_cnt, stall_cnt_next, stall_inc;

    logic [15:0] busy_q, busy_next;
    logic [4:0]  inflight_q;
    logic        issue_valid_q;
    logic [15:0] issue_instr_q;

    logic        has_dest, use_a, use_b;
    logic [3:0]  dest, src_a, src_b;
    logic [15:0] bypass_mask, src_busy;
    logic        hazard, wb_frees, full, stall_req, issue;
    logic        fetch_stall, deadlock_err;

    // Field decode
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        has_dest = 1'b0;
        dest     = 4'h0;
        use_a    = 1'b0;
        src_a    = 4'h0;
        use_b    = 1'b0;
        src_b    = 4'h0;
        case (bus.instr[15:12])
            OP_LOAD: begin
                has_dest = 1'b1;
                dest     = bus.instr[3:0];
            end
            OP_STORE: begin
                use_a = 1'b1;
                src_a = bus.instr[3:0];
            end
            default: begin
                has_dest = 1'b1;
                dest     = bus.instr[11:8];
                use_a    = 1'b1;
                src_a    = bus.instr[7:4];
                use_b    = 1'b1;
                src_b    = bus.instr[3:0];
            end
        endcase
    end

    // A same-cycle writeback may hide a source's busy bit (bypass), but
    // never a destination's: the WAW check always uses the raw scoreboard.
    assign bypass_mask = (WB_BYPASS != 0 && bus.wb_valid) ? (16'h0001 << bus.wb_reg) : 16'h0000;
    assign src_busy    = busy_q & ~bypass_mask;
    assign hazard      = (use_a & src_busy[src_a]) | (use_b & src_busy[src_b])
                       | (has_dest & busy_q[dest]);
    assign wb_frees    = bus.wb_valid & busy_q[bus.wb_reg];
    assign full        = has_dest & (inflight_q == 5'(MAX_INFLIGHT)) & ~wb_frees;
    assign stall_req   = bus.instr_valid & (hazard | full);
    assign issue       = bus.instr_valid & ~fetch_stall;

    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    // FSM: next state. stall_inc is the length of the current stall run
    // including this cycle.
    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        stall_inc      = (state == ST_RUN) ? CNT_W'(1) : stall_cnt + CNT_W'(1);
        case (state)
            ST_RUN, ST_STALL: begin
                if (stall_req) begin
                    stall_cnt_next = stall_inc;
                    state_next     = (stall_inc >= CNT_W'(STALL_LIMIT)) ? ST_ERR : ST_STALL;
                end else begin
                    stall_cnt_next = '0;
                    state_next     = ST_RUN;
                end
            end
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_RUN;
        endcase
    end

    // FSM: outputs. deadlock_err comes straight from the state flops.
    always_comb begin
        deadlock_err = (state == ST_ERR);
        fetch_stall  = (state == ST_ERR) | stall_req;
    end

    // Scoreboard next value: clear on writeback first, then set on issue so
    // that a set and clear of the same register leaves it busy.
    always_comb begin
        busy_next = busy_q;
        if (bus.wb_valid) busy_next[bus.wb_reg] = 1'b0;
        if (issue && has_dest) busy_next[dest] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= 16'h0000;
            inflight_q    <= 5'd0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= 16'h0000;
        end else begin
            busy_q        <= busy_next;
            inflight_q    <= 5'($countones(busy_next));
            issue_valid_q <= issue;
            issue_instr_q <= issue ? bus.instr : 16'h0000;
        end
    end

    assign bus.fetch_stall  = fetch_stall;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_instr  = issue_instr_q;
    assign bus.busy         = busy_q;
    assign bus.inflight     = inflight_q;
    assign bus.deadlock_err = deadlock_err;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard_ctrl
//   Directed scenarios with literal expectations, then randomized traffic,
//   all checked every cycle against a behavioural scoreboard model.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard_ctrl;

    localparam int MAX_INFLIGHT = 2;
    localparam int STALL_LIMIT  = 4;
    localparam int WB_BYPASS    = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_ctrl_if bus();

    hazard_scoreboard_ctrl #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .STALL_LIMIT  (STALL_LIMIT),
        .WB_BYPASS    (WB_BYPASS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_busy[16];
    bit          m_err;
    int          m_run;
    bit          m_iv;
    logic [15:0] m_ii;
    bit          m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Returns dest and sources as register numbers, -1 when absent.
    function automatic void decode(input logic [15:0] ins, output int d, output int a, output int b);
        case (ins[15:12])
            4'hE:    begin d = int'(ins[3:0]); a = -1; b = -1; end
            4'hF:    begin d = -1; a = int'(ins[3:0]); b = -1; end
            default: begin d = int'(ins[11:8]); a = int'(ins[7:4]); b = int'(ins[3:0]); end
        endcase
    endfunction

    function automatic int count_busy();
        int n = 0;
        foreach (m_busy[i]) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [15:0] busy_vec();
        logic [15:0] v = 16'h0;
        foreach (m_busy[i]) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit model_stall(input bit iv, input logic [15:0] ins, input bit wv, input logic [3:0] wr);
        int d, a, b;
        bit haz, full;
        decode(ins, d, a, b);
        haz = 1'b0;
        if (a >= 0 && m_busy[a] && !(WB_BYPASS != 0 && wv && int'(wr) == a)) haz = 1'b1;
        if (b >= 0 && m_busy[b] && !(WB_BYPASS != 0 && wv && int'(wr) == b)) haz = 1'b1;
        if (d >= 0 && m_busy[d]) haz = 1'b1;
        full = (d >= 0) && (count_busy() == MAX_INFLIGHT) && !(wv && m_busy[wr]);
        return m_err || (iv && (haz || full));
    endfunction

    task automatic model_clock(input bit iv, input logic [15:0] ins, input bit wv, input logic [3:0] wr, input bit stall);
        int d, a, b;
        bit iss;
        decode(ins, d, a, b);
        iss = iv && !stall;
        if (wv) m_busy[wr] = 1'b0;
        if (iss && d >= 0) m_busy[d] = 1'b1;
        m_iv = iss;
        m_ii = iss ? ins : 16'h0000;
        if (!m_err) begin
            if (iv && stall) begin
                m_run++;
                if (m_run >= STALL_LIMIT) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_err = 1'b0;
        m_run = 0;
        m_iv  = 1'b0;
        m_ii  = 16'h0000;
    endtask

    task automatic check_outputs();
        check("issue_valid",  bus.issue_valid,  m_iv);
        check("issue_instr",  bus.issue_instr,  m_ii);
        check("busy",         bus.busy,         busy_vec());
        check("inflight",     bus.inflight,     count_busy());
        check("deadlock_err", bus.deadlock_err, m_err);
    endtask

    // One clock cycle; starts and ends just after a falling edge.
    task automatic cycle(input bit iv, input logic [15:0] ins, input bit wv, input logic [3:0] wr);
        bus.instr_valid = iv;
        bus.instr       = ins;
        bus.wb_valid    = wv;
        bus.wb_reg      = wr;
        #1;
        m_stall = model_stall(iv, ins, wv, wr);
        check("fetch_stall", bus.fetch_stall, m_stall);
        @(posedge clk);
        model_clock(iv, ins, wv, wr, m_stall);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset(input int offset);
        #(offset);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("fetch_stall_rst", bus.fetch_stall,
              model_stall(bus.instr_valid, bus.instr, bus.wb_valid, bus.wb_reg));
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] gen_instr();
        logic [3:0] op;
        case ($urandom % 4)
            0:       op = 4'hE;
            1:       op = 4'hF;
            default: op = 4'($urandom_range(0, 13));
        endcase
        return {op, 1'b0, 3'($urandom), 1'b0, 3'($urandom), 1'b0, 3'($urandom)};
    endfunction

    initial begin
        bit          held;
        bit          cur_iv;
        logic [15:0] cur;
        bit          wv;
        logic [3:0]  wr;
        int          q[$];

        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.wb_valid    = 1'b0;
        bus.wb_reg      = 4'h0;
        @(negedge clk);
        model_reset();
        check_outputs();
        check("fetch_stall_reset", bus.fetch_stall, 1'b0);
        rst = 1'b0;

        // ADD r3 = r1 + r2 issues with one cycle latency
        cycle(1'b1, 16'h0312, 1'b0, 4'h0);
        check("lit_add_iv",    bus.issue_valid, 1'b1);
        check("lit_add_instr", bus.issue_instr, 16'h0312);
        check("lit_add_busy",  bus.busy,        16'h0008);
        check("lit_add_infl",  bus.inflight,    5'd1);

        // RAW on r3 stalls, then resolves via same-cycle writeback bypass
        cycle(1'b1, 16'h0534, 1'b0, 4'h0);
        check("lit_raw_iv", bus.issue_valid, 1'b0);
        cycle(1'b1, 16'h0534, 1'b1, 4'h3);
        check("lit_byp_instr", bus.issue_instr, 16'h0534);
        check("lit_byp_busy",  bus.busy,        16'h0020);

        // WAW on r4 stalls even with writeback of r4 that cycle
        cycle(1'b0, 16'h0000, 1'b1, 4'h5);
        cycle(1'b1, 16'hE204, 1'b0, 4'h0);
        cycle(1'b1, 16'hE204, 1'b1, 4'h4);
        check("lit_waw_iv",   bus.issue_valid, 1'b0);
        check("lit_waw_busy", bus.busy,        16'h0000);
        cycle(1'b1, 16'hE204, 1'b0, 4'h0);
        check("lit_waw_issue", bus.issue_instr, 16'hE204);
        check("lit_waw_busy2", bus.busy,        16'h0010);

        // In-flight cap: third write waits until a writeback frees a slot
        cycle(1'b0, 16'h0000, 1'b1, 4'h4);
        cycle(1'b1, 16'hE201, 1'b0, 4'h0);
        cycle(1'b1, 16'hE202, 1'b0, 4'h0);
        check("lit_cap_infl", bus.inflight, 5'd2);
        cycle(1'b1, 16'hE205, 1'b0, 4'h0);
        check("lit_cap_iv", bus.issue_valid, 1'b0);
        cycle(1'b1, 16'hE205, 1'b1, 4'h1);
        check("lit_cap_issue", bus.issue_instr, 16'hE205);
        check("lit_cap_busy",  bus.busy,        16'h0024);

        // Persistent stall reaches the deadlock limit
        for (int i = 0; i < STALL_LIMIT - 1; i++) cycle(1'b1, 16'h0620, 1'b0, 4'h0);
        check("lit_dl_before", bus.deadlock_err, 1'b0);
        cycle(1'b1, 16'h0620, 1'b0, 4'h0);
        check("lit_dl_set", bus.deadlock_err, 1'b1);
        cycle(1'b1, 16'h0620, 1'b1, 4'h2);
        check("lit_dl_busy",  bus.busy,         16'h0020);
        check("lit_dl_stick", bus.deadlock_err, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 4'h0);
        check("lit_dl_stall", bus.fetch_stall,  1'b1);
        check("lit_dl_stay",  bus.deadlock_err, 1'b1);
        async_reset(2);
        check("lit_dl_clear", bus.deadlock_err, 1'b0);

        // Async reset mid-stall; the held instruction issues afterwards
        cycle(1'b1, 16'hE201, 1'b0, 4'h0);
        cycle(1'b1, 16'hE202, 1'b0, 4'h0);
        cycle(1'b1, 16'h0612, 1'b0, 4'h0);
        check("lit_pre_rst_stall", bus.fetch_stall, 1'b1);
        async_reset(3);
        check("lit_rst_busy", bus.busy, 16'h0000);
        cycle(1'b1, 16'h0612, 1'b0, 4'h0);
        check("lit_post_rst_instr", bus.issue_instr, 16'h0612);
        check("lit_post_rst_busy",  bus.busy,        16'h0040);

        // Randomized traffic; fetch holds a stalled instruction
        held   = 1'b0;
        cur_iv = 1'b0;
        cur    = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 97 == 96 || (m_err && $urandom % 4 == 0)) begin
                async_reset(int'($urandom_range(1, 3)));
            end
            if (!held) begin
                cur_iv = ($urandom % 4) != 0;
                cur    = gen_instr();
            end
            wv = ($urandom % 3) == 0;
            q.delete();
            foreach (m_busy[r]) if (m_busy[r]) q.push_back(r);
            if (q.size() > 0 && ($urandom % 4) != 0) wr = 4'(q[$urandom % q.size()]);
            else                                     wr = 4'($urandom % 16);
            cycle(cur_iv, cur, wv, wr);
            held = cur_iv && m_stall && !m_err;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
